// File: rtl/vga_pkg.sv
// Shared timing defaults, pattern encoding and CGA colour constants for the
// 640x480 test-pattern source.
package vga_pkg;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t DEF_H_ACTIVE = 10'd640;
    localparam cnt_t DEF_H_FP     = 10'd16;
    localparam cnt_t DEF_H_SYNC   = 10'd96;
    localparam cnt_t DEF_H_TOTAL  = 10'd800;
    localparam cnt_t DEF_V_ACTIVE = 10'd480;
    localparam cnt_t DEF_V_FP     = 10'd10;
    localparam cnt_t DEF_V_SYNC   = 10'd2;
    localparam cnt_t DEF_V_TOTAL  = 10'd525;

    localparam cnt_t N_BARS = 10'd16;

    typedef enum logic [1:0] {
        BARS_V  = 2'd0,
        BARS_H  = 2'd1,
        CHECKER = 2'd2,
        BORDER  = 2'd3
    } pattern_e;

    localparam logic [3:0] BLACK = 4'h0;
    localparam logic [3:0] WHITE = 4'hF;

endpackage

// File: rtl/vga_sync_counter.sv
// Raster position counters and combinational decode of syncs, active region
// and frame markers for the current (h,v) position.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter cnt_t H_ACTIVE = DEF_H_ACTIVE,
    parameter cnt_t H_FP     = DEF_H_FP,
    parameter cnt_t H_SYNC   = DEF_H_SYNC,
    parameter cnt_t H_TOTAL  = DEF_H_TOTAL,
    parameter cnt_t V_ACTIVE = DEF_V_ACTIVE,
    parameter cnt_t V_FP     = DEF_V_FP,
    parameter cnt_t V_SYNC   = DEF_V_SYNC,
    parameter cnt_t V_TOTAL  = DEF_V_TOTAL
)(
    input  logic clk,
    input  logic rst,
    output cnt_t h,
    output cnt_t v,
    output logic active,
    output logic hsync,
    output logic vsync,
    output logic frame_start,
    output logic line_end,
    output logic frame_end
);

    cnt_t h_r;
    cnt_t v_r;

    // Raster counters: h sweeps one line, v advances on each line wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_r <= 10'd0;
            v_r <= 10'd0;
        end else if (line_end) begin
            h_r <= 10'd0;
            if (frame_end) begin
                v_r <= 10'd0;
            end else begin
                v_r <= v_r + 10'd1;
            end
        end else begin
            h_r <= h_r + 10'd1;
        end
    end

    assign h           = h_r;
    assign v           = v_r;
    assign line_end    = (h_r == H_TOTAL - 10'd1);
    assign frame_end   = line_end && (v_r == V_TOTAL - 10'd1);
    assign frame_start = (h_r == 10'd0) && (v_r == 10'd0);
    assign active      = (h_r < H_ACTIVE) && (v_r < V_ACTIVE);
    assign hsync       = !((h_r >= H_ACTIVE + H_FP) && (h_r < H_ACTIVE + H_FP + H_SYNC));
    assign vsync       = !((v_r >= V_ACTIVE + V_FP) && (v_r < V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/vga_cga_pattern_gen.sv
// 640x480 raster source producing a 4-bit CGA colour index from one of four
// test patterns; every output is registered so all describe the same pixel.
module vga_cga_pattern_gen
    import vga_pkg::*;
#(
    parameter cnt_t H_ACTIVE = DEF_H_ACTIVE,
    parameter cnt_t H_FP     = DEF_H_FP,
    parameter cnt_t H_SYNC   = DEF_H_SYNC,
    parameter cnt_t H_TOTAL  = DEF_H_TOTAL,
    parameter cnt_t V_ACTIVE = DEF_V_ACTIVE,
    parameter cnt_t V_FP     = DEF_V_FP,
    parameter cnt_t V_SYNC   = DEF_V_SYNC,
    parameter cnt_t V_TOTAL  = DEF_V_TOTAL
)(
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [1:0] i_Pattern_Sel,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic       o_Active,
    output logic [9:0] o_Col,
    output logic [9:0] o_Row,
    output logic       o_Frame_Start,
    output logic [3:0] o_Color
);

    localparam cnt_t BAR_W = H_ACTIVE / N_BARS;
    localparam cnt_t BAR_H = V_ACTIVE / N_BARS;

    cnt_t       h_s;
    cnt_t       v_s;
    logic       active_s;
    logic       hsync_s;
    logic       vsync_s;
    logic       frame_start_s;
    logic       line_end_s;
    logic       frame_end_s;
    logic       border_s;
    logic [3:0] color_s;

    pattern_e   pattern_r;
    cnt_t       frame_cnt_r;
    cnt_t       bar_px_r;
    cnt_t       bar_col_r;
    cnt_t       bar_ln_r;
    cnt_t       bar_row_r;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_TOTAL  (V_TOTAL)
    ) u_sync (
        .clk         (i_Clk),
        .rst         (i_Rst),
        .h           (h_s),
        .v           (v_s),
        .active      (active_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .frame_start (frame_start_s),
        .line_end    (line_end_s),
        .frame_end   (frame_end_s)
    );

    // Pattern and frame count change only at the last pixel of the frame.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            pattern_r   <= BARS_V;
            frame_cnt_r <= 10'd0;
        end else if (frame_end_s) begin
            pattern_r   <= pattern_e'(i_Pattern_Sel);
            frame_cnt_r <= frame_cnt_r + 10'd1;
        end
    end

    // Vertical-bar index: pixel sub-counter rolls every BAR_W, restarts each line.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            bar_px_r  <= 10'd0;
            bar_col_r <= 10'd0;
        end else if (line_end_s) begin
            bar_px_r  <= 10'd0;
            bar_col_r <= 10'd0;
        end else if (bar_px_r == BAR_W - 10'd1) begin
            bar_px_r  <= 10'd0;
            bar_col_r <= bar_col_r + 10'd1;
        end else begin
            bar_px_r  <= bar_px_r + 10'd1;
        end
    end

    // Horizontal-bar index: line sub-counter rolls every BAR_H, restarts each frame.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            bar_ln_r  <= 10'd0;
            bar_row_r <= 10'd0;
        end else if (frame_end_s) begin
            bar_ln_r  <= 10'd0;
            bar_row_r <= 10'd0;
        end else if (line_end_s) begin
            if (bar_ln_r == BAR_H - 10'd1) begin
                bar_ln_r  <= 10'd0;
                bar_row_r <= bar_row_r + 10'd1;
            end else begin
                bar_ln_r  <= bar_ln_r + 10'd1;
            end
        end
    end

    assign border_s = (h_s == 10'd0) || (h_s == H_ACTIVE - 10'd1) ||
                      (v_s == 10'd0) || (v_s == V_ACTIVE - 10'd1);

    // Colour mux; blanking always forces black.
    always_comb begin
        color_s = BLACK;
        if (active_s) begin
            case (pattern_r)
                BARS_V:  color_s = bar_col_r[3:0];
                BARS_H:  color_s = bar_row_r[3:0];
                CHECKER: color_s = (h_s[5] ^ v_s[5]) ? WHITE : BLACK;
                BORDER:  color_s = border_s ? WHITE : frame_cnt_r[9:6];
                default: color_s = BLACK;
            endcase
        end else begin
            color_s = BLACK;
        end
    end

    // Output stage: all outputs register the same pixel together.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Col         <= 10'd0;
            o_Row         <= 10'd0;
            o_Active      <= 1'b0;
            o_HSync       <= 1'b1;
            o_VSync       <= 1'b1;
            o_Frame_Start <= 1'b0;
            o_Color       <= BLACK;
        end else begin
            o_Col         <= h_s;
            o_Row         <= v_s;
            o_Active      <= active_s;
            o_HSync       <= hsync_s;
            o_VSync       <= vsync_s;
            o_Frame_Start <= frame_start_s;
            o_Color       <= color_s;
        end
    end

endmodule

// File: doc/vga_cga_pattern_gen.md
# vga_cga_pattern_gen

Upstream source for the 16-colour VGA path. It generates 640x480@60 Hz raster timing from the 25 MHz pixel clock and produces a 4-bit CGA colour index per pixel from one of four built-in test patterns. It also emits syncs, an active-video flag and pixel coordinates, all aligned to the same cycle. The colour index feeds the CGA-to-9-bit RGB converter combinationally; the syncs travel alongside it.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_TOTAL, 800, pixels per line including blanking
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_TOTAL, 525, lines per frame

Ports:
- i_Clk  in  1  25 MHz pixel clock
- i_Rst  in  1  reset, asynchronous, active-high
- i_Pattern_Sel  in  2  pattern request; sampled only at end of frame
- o_HSync  out  1  horizontal sync, active-low
- o_VSync  out  1  vertical sync, active-low
- o_Active  out  1  high during visible pixels
- o_Col  out  10  current column, 0..H_TOTAL-1
- o_Row  out  10  current row, 0..V_TOTAL-1
- o_Frame_Start  out  1  one-cycle pulse at pixel (0,0)
- o_Color  out  4  CGA colour index; 0 whenever o_Active=0

## Operation
- Horizontal counter h runs 0..H_TOTAL-1 and then wraps to 0. When h wraps, vertical counter v increments; v wraps from V_TOTAL-1 to 0.
- A 10-bit frame counter increments on every v wrap and wraps naturally at 1023.
- Active region: h<H_ACTIVE and v<V_ACTIVE.
- HSync is low for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
- VSync is low for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- The pattern register loads i_Pattern_Sel when (h,v)=(H_TOTAL-1,V_TOTAL-1). The new pattern applies from the next pixel (0,0). A change to i_Pattern_Sel mid-frame has no effect until then.
- Patterns (visible region only):
  - 0: 16 vertical bars, 40 px wide. Colour = bar index 0..15 from left.
  - 1: 16 horizontal bars, 30 lines high. Colour = bar index 0..15 from top.
  - 2: checkerboard of 32x32 cells. Colour = 4'hF if col[5]^row[5], else 4'h0.
  - 3: white (4'hF) 1-pixel border at col 0, col 639, row 0 and row 479. The interior colour is frame_count[9:6], so it steps every 64 frames.
- Bar indices come from sub-counters that reset every 40 px or 30 lines. No divider is allowed.
- Widths: all counters are 10 bits unsigned. Comparisons use parameters only; no magic numbers in the logic.

## Timing
- Every output is registered. o_Col, o_Row, o_Active, o_HSync, o_VSync, o_Frame_Start and o_Color always describe the same pixel in the same cycle. The downstream colour converter is combinational, so the RGB value stays aligned with the syncs.
- Reset values, asserted asynchronously:
  - h=v=0, frame count 0, pattern register 0
  - o_Col=0, o_Row=0, o_Active=0, o_Frame_Start=0, o_Color=0
  - o_HSync=1, o_VSync=1
- First rising edge after reset release: outputs show pixel (0,0) with o_Active=1 and o_Frame_Start=1. o_Color is pattern 0, bar 0, giving 4'h0.
- Reset asserted mid-frame forces the reset values immediately. Operation restarts at (0,0) with pattern 0; there is no partial-frame recovery.
- Line period is exactly H_TOTAL cycles. Frame period is exactly H_TOTAL*V_TOTAL = 420000 cycles.
- o_Frame_Start pulses once per frame, for exactly one cycle.

## Structure
- Shared package vga_pkg contains:
  - default 640x480 timing constants
  - a 2-bit pattern enumeration: BARS_V, BARS_H, CHECKER, BORDER
  - CGA index constants BLACK=4'h0 and WHITE=4'hF
- Sub-module vga_sync_counter holds:
  - the h/v counters and wrap logic
  - outputs for h, v, active, hsync, vsync, frame_start and end_of_frame
- The top level instantiates vga_sync_counter and adds the pattern register, bar sub-counters, frame counter and colour mux.

## Test plan
- Reset, then run 2 frames:
  - HSync low for exactly 96 cycles starting at h=656
  - VSync low for exactly 2 lines starting at v=490
  - o_Frame_Start high once every 420000 cycles
- Pattern 0:
  - o_Color=0 at col 0..39, =1 at col 40, =15 at col 600..639
  - o_Color=0 for col 640..799
- Set i_Pattern_Sel=2 at (100,100):
  - pattern 0 continues until (799,524)
  - at (0,0) o_Color=0; at col 32 of row 0 o_Color=F; at col 32 of row 32 o_Color=0
- Pattern 3 over 130 frames:
  - border pixels always F
  - interior = 0 for frames 0..63, 1 for frames 64..127
- Assert i_Rst at (300,200), release after 3 cycles:
  - outputs at reset values during reset (HSync=VSync=1, Color=0)
  - first post-release cycle shows (0,0) with Frame_Start=1 and pattern 0
